// File: rtl/bpsk_frame_controller.sv
// BPSK receive framer: hunts for the sync word in either polarity, reads a
// length header, packs payload bits into bytes and queues them in a small
// output FIFO. It aborts the frame and asks the demodulator to re-acquire
// when symbols stop arriving mid-frame.
module bpsk_frame_controller #(
  parameter int                   SYNC_BITS      = 16,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD      = 16'h2DD4,
  parameter int                   MAX_LEN        = 32,
  parameter int                   TIMEOUT_CYCLES = 65535,
  parameter int                   FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_write,
  output logic [7:0] byte_data,
  output logic       byte_last,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_active,
  output logic       sync_invert,
  output logic       demod_restart,
  output logic       frame_done,
  output logic       frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B    = 8'(MAX_LEN);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_LENGTH  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]           state;
  logic [SYNC_BITS-2:0] shift_reg;
  logic [SYNC_BITS-1:0] shift_next;
  logic [2:0]           bit_cnt;
  logic [7:0]           byte_cnt;
  logic [7:0]           len_reg;
  logic [6:0]           data_shift;
  logic [7:0]           assembled;
  logic [TW-1:0]        timeout_cnt;

  logic [8:0]           fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;

  logic eff;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic byte_complete;
  logic last_byte;
  logic timeout_hit;

  // Only the last SYNC_BITS-1 raw bits are stored; the live bit completes the window.
  assign shift_next    = {shift_reg, bit_in};
  assign eff           = bit_in ^ sync_invert;
  assign assembled     = {data_shift, eff};

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign byte_valid    = !fifo_empty;
  assign pop           = byte_valid && byte_ready;

  assign frame_active  = (state == ST_LENGTH) || (state == ST_PAYLOAD);
  assign byte_complete = bit_write && (state == ST_PAYLOAD) && (bit_cnt == 3'd7);
  assign last_byte     = (byte_cnt == len_reg - 8'd1);
  assign push          = byte_complete && (!fifo_full || pop);
  assign timeout_hit   = frame_active && !bit_write && (timeout_cnt == TIMEOUT_LAST);

  // The head entry is shown only while valid, so an empty FIFO presents zeros.
  assign byte_data     = byte_valid ? fifo_mem[rd_ptr[AW-1:0]][7:0] : 8'd0;
  assign byte_last     = byte_valid && fifo_mem[rd_ptr[AW-1:0]][8];

  // Frame sequencer: sync hunt, length header, payload assembly and the silence watchdog.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_HUNT;
      shift_reg     <= '0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= 8'd0;
      len_reg       <= 8'd0;
      data_shift    <= 7'd0;
      timeout_cnt   <= '0;
      sync_invert   <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      demod_restart <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      demod_restart <= 1'b0;

      if (frame_active && !bit_write) begin
        timeout_cnt <= timeout_cnt + TW'(1);
      end else begin
        timeout_cnt <= '0;
      end

      case (state)
        ST_HUNT: begin
          if (bit_write) begin
            if (shift_next == SYNC_WORD || shift_next == ~SYNC_WORD) begin
              sync_invert <= (shift_next != SYNC_WORD);
              state       <= ST_LENGTH;
              shift_reg   <= '0;
              bit_cnt     <= 3'd0;
              data_shift  <= 7'd0;
            end else begin
              shift_reg <= shift_next[SYNC_BITS-2:0];
            end
          end
        end

        ST_LENGTH, ST_PAYLOAD: begin
          if (bit_write) begin
            data_shift <= assembled[6:0];
            bit_cnt    <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_LENGTH) begin
                if (assembled == 8'd0 || assembled > MAX_LEN_B) begin
                  frame_error <= 1'b1;
                  state       <= ST_HUNT;
                end else begin
                  len_reg  <= assembled;
                  byte_cnt <= 8'd0;
                  state    <= ST_PAYLOAD;
                end
              end else if (!push) begin
                frame_error <= 1'b1;
                state       <= ST_HUNT;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
                if (last_byte) begin
                  frame_done <= 1'b1;
                  state      <= ST_HUNT;
                end
              end
            end
          end else if (timeout_hit) begin
            frame_error   <= 1'b1;
            demod_restart <= 1'b1;
            state         <= ST_HUNT;
            bit_cnt       <= 3'd0;
            timeout_cnt   <= '0;
          end
        end

        default: state <= ST_HUNT;
      endcase
    end
  end

  // FIFO pointers; reset discards any queued bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage carries the byte plus its end-of-frame flag.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {last_byte, assembled};
  end

endmodule

// File: tb/tb_bpsk_frame_controller.sv
// Self-checking bench for bpsk_frame_controller: expected payload bytes are
// queued as frames are driven and compared as the DUT hands them out.
module tb_bpsk_frame_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_write;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_active;
  logic       sync_invert;
  logic       demod_restart;
  logic       frame_done;
  logic       frame_error;

  int check_count = 0;
  int error_count = 0;
  int popped      = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int restart_cnt = 0;

  logic [8:0] sb [$];
  logic [8:0] exp_entry;

  bpsk_frame_controller #(
    .SYNC_BITS      (16),
    .SYNC_WORD      (16'h2DD4),
    .MAX_LEN        (32),
    .TIMEOUT_CYCLES (100),
    .FIFO_DEPTH     (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bit_in        (bit_in),
    .bit_write     (bit_write),
    .byte_data     (byte_data),
    .byte_last     (byte_last),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .frame_active  (frame_active),
    .sync_invert   (sync_invert),
    .demod_restart (demod_restart),
    .frame_done    (frame_done),
    .frame_error   (frame_error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One bit strobe, then the line stays idle for the rest of the gap.
  task automatic applyStimulus(input logic b, input int gap);
    bit_in    = b;
    bit_write = 1'b1;
    @(posedge clock);
    #1;
    bit_write = 1'b0;
    repeat (gap - 1) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic inv);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i] ^ inv, 10);
  endtask

  task automatic send_sync(input logic inv);
    logic [15:0] sync_pat;
    sync_pat = 16'h2DD4;
    for (int i = 15; i >= 0; i--) applyStimulus(sync_pat[i] ^ inv, 10);
  endtask

  // Drives a whole frame; only the first nkeep bytes are expected to emerge.
  task automatic send_frame(input logic inv, input logic [7:0] len, input logic [63:0] data,
                            input int nsend, input int nkeep);
    logic [7:0] b;
    send_sync(inv);
    send_byte(len, inv);
    for (int n = 0; n < nsend; n++) begin
      b = data[63 - 8*n -: 8];
      if (n < nkeep) sb.push_back({(n == int'(len) - 1), b});
      send_byte(b, inv);
    end
  endtask

  // Output monitor: scoreboard compare on every handshake and pulse counting.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done)    done_cnt++;
      if (frame_error)   err_cnt++;
      if (demod_restart) restart_cnt++;
      if (byte_valid && byte_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_byte", 32'(sb.size()), 1);
        end else begin
          exp_entry = sb.pop_front();
          checkOutput("byte", 32'({byte_last, byte_data}), 32'(exp_entry));
          popped++;
        end
      end
    end
  end

  initial begin
    int d0, e0, p0, r0, lat;
    reset      = 1'b1;
    bit_in     = 1'b0;
    bit_write  = 1'b0;
    byte_ready = 1'b1;
    #2;
    checkOutput("reset_outputs", 32'({byte_data, byte_last, byte_valid, frame_active, sync_invert,
                                      demod_restart, frame_done, frame_error}), 0);
    idle(3);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Normal frame
    d0 = done_cnt; e0 = err_cnt; p0 = popped;
    send_frame(1'b0, 8'h03, 64'hA53C7E00_00000000, 3, 3);
    idle(5);
    checkOutput("normal_done", 32'(done_cnt - d0), 1);
    checkOutput("normal_error", 32'(err_cnt - e0), 0);
    checkOutput("normal_popped", 32'(popped - p0), 3);
    checkOutput("normal_invert", 32'(sync_invert), 0);

    // Inverted polarity
    d0 = done_cnt; e0 = err_cnt; p0 = popped;
    send_frame(1'b1, 8'h03, 64'hA53C7E00_00000000, 3, 3);
    idle(5);
    checkOutput("inv_invert", 32'(sync_invert), 1);
    checkOutput("inv_done", 32'(done_cnt - d0), 1);
    checkOutput("inv_popped", 32'(popped - p0), 3);
    checkOutput("inv_error", 32'(err_cnt - e0), 0);

    // Bad lengths, then a good frame
    e0 = err_cnt; p0 = popped;
    send_frame(1'b0, 8'h00, 64'h0, 0, 0);
    checkOutput("len0_error", 32'(err_cnt - e0), 1);
    checkOutput("len0_active", 32'(frame_active), 0);
    send_frame(1'b0, 8'h21, 64'h0, 0, 0);
    checkOutput("len33_error", 32'(err_cnt - e0), 2);
    checkOutput("len33_valid", 32'(byte_valid), 0);
    checkOutput("badlen_popped", 32'(popped - p0), 0);
    d0 = done_cnt;
    send_frame(1'b0, 8'h01, 64'h99000000_00000000, 1, 1);
    idle(5);
    checkOutput("after_badlen_done", 32'(done_cnt - d0), 1);
    checkOutput("after_badlen_popped", 32'(popped - p0), 1);

    // Backpressure and overflow
    byte_ready = 1'b0;
    d0 = done_cnt; e0 = err_cnt; p0 = popped;
    send_frame(1'b0, 8'h06, 64'h11223344_55660000, 6, 4);
    checkOutput("ovf_error", 32'(err_cnt - e0), 1);
    checkOutput("ovf_done", 32'(done_cnt - d0), 0);
    checkOutput("ovf_valid", 32'(byte_valid), 1);
    checkOutput("ovf_hold_head", 32'({byte_last, byte_data}), 32'h011);
    checkOutput("ovf_active", 32'(frame_active), 0);
    byte_ready = 1'b1;
    idle(10);
    checkOutput("ovf_drained", 32'(popped - p0), 4);
    checkOutput("ovf_sb_empty", 32'(sb.size()), 0);
    checkOutput("ovf_valid_after", 32'(byte_valid), 0);

    // Timeout after three length bits
    r0 = restart_cnt; e0 = err_cnt;
    send_sync(1'b0);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b0, 1);
    lat = 151;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clock);
      #1;
      if (demod_restart) begin
        lat = k;
        break;
      end
    end
    checkOutput("timeout_latency", 32'(lat), 100);
    checkOutput("timeout_error", 32'(frame_error), 1);
    checkOutput("timeout_active", 32'(frame_active), 0);
    idle(5);
    checkOutput("timeout_restart_cnt", 32'(restart_cnt - r0), 1);
    checkOutput("timeout_error_cnt", 32'(err_cnt - e0), 1);

    // A strobe on the expiry cycle keeps the frame alive
    r0 = restart_cnt; e0 = err_cnt; d0 = done_cnt; p0 = popped;
    send_sync(1'b0);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b0, 1);
    repeat (99) @(posedge clock);
    #1;
    applyStimulus(1'b0, 10);
    checkOutput("expiry_active", 32'(frame_active), 1);
    checkOutput("expiry_restart", 32'(restart_cnt - r0), 0);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    sb.push_back({1'b0, 8'h5A});
    send_byte(8'h5A, 1'b0);
    sb.push_back({1'b1, 8'hC3});
    send_byte(8'hC3, 1'b0);
    idle(5);
    checkOutput("expiry_done", 32'(done_cnt - d0), 1);
    checkOutput("expiry_error", 32'(err_cnt - e0), 0);
    checkOutput("expiry_popped", 32'(popped - p0), 2);

    // Asynchronous reset with two bytes queued
    byte_ready = 1'b0;
    send_sync(1'b0);
    send_byte(8'h03, 1'b0);
    sb.push_back({1'b0, 8'hA5});
    send_byte(8'hA5, 1'b0);
    sb.push_back({1'b0, 8'h3C});
    send_byte(8'h3C, 1'b0);
    checkOutput("prereset_valid", 32'(byte_valid), 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", 32'({byte_data, byte_last, byte_valid, frame_active, sync_invert,
                                         demod_restart, frame_done, frame_error}), 0);
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    byte_ready = 1'b1;
    d0 = done_cnt; p0 = popped;
    send_frame(1'b0, 8'h03, 64'hA53C7E00_00000000, 3, 3);
    idle(5);
    checkOutput("postreset_done", 32'(done_cnt - d0), 1);
    checkOutput("postreset_popped", 32'(popped - p0), 3);
    checkOutput("final_sb_empty", 32'(sb.size()), 0);
    checkOutput("total_restarts", 32'(restart_cnt), 1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
